math_expression_inverse: RTL and testbench



---
 rtl/math_expression_inverse_if.sv | 27 ++
 rtl/math_expression_inverse.sv | 143 ++++++++++++++
 tb/tb_math_expression_inverse.sv | 120 ++++++++++++
 3 files changed

// File: rtl/math_expression_inverse_if.sv
// Job bus for math_expression_inverse: operand capture on start, result/flags with a one-cycle valid tick.
interface math_expression_inverse_if #(
  parameter int W = 32
);
  logic                  start;
  logic signed [2*W+3:0] q;
  logic                  rmd;
  logic signed [W-1:0]   a;
  logic signed [W-1:0]   b;
  logic signed [W-1:0]   d;
  logic signed [W-1:0]   c;
  logic                  valid;
  logic                  busy;
  logic                  err_div0;
  logic                  inexact;
  logic                  ovf;

  modport master (
    output start, q, rmd, a, b, d,
    input  c, valid, busy, err_div0, inexact, ovf
  );

  modport slave (
    input  start, q, rmd, a, b, d,
    output c, valid, busy, err_div0, inexact, ovf
  );
endinterface

// File: rtl/math_expression_inverse.sv
// Recovers c from a math_expression result with one shared restoring divider run twice; 2*NW+4 cycles (3 on a==b).
// start is taken only in IDLE, never queued; MATH_INVERSE_EXACT_CHECK_EN builds the remainder (inexact) check.
module math_expression_inverse #(
  parameter int W = 32
) (
  input  logic                       clk,
  input  logic                       reset,
  math_expression_inverse_if.slave   io
);
  localparam int NW = 2*W + 6;
  localparam int CW = $clog2(NW);

  typedef enum logic [2:0] {IDLE, PREP, DIV1, FIX1, DIV2, FIX2, DONE} state_t;

  state_t state, state_nxt;

  logic signed [2*W+3:0] q_r;
  logic                  rmd_r;
  logic signed [W-1:0]   a_r, b_r, d_r;
  logic [NW-1:0]         dvd, dvs, rem;
  logic [CW-1:0]         cnt;
  logic                  neg, div0;
  logic signed [W-1:0]   c_r;
  logic                  err_r, ovf_r;

  function automatic logic [NW-1:0] mag(input logic [NW-1:0] v);
    return v[NW-1] ? -v : v;
  endfunction

  logic signed [NW-1:0] q_x, d_x, a_x, b_x, n_s, d1_s;
  assign q_x  = NW'(q_r);
  assign d_x  = NW'(d_r);
  assign a_x  = NW'(a_r);
  assign b_x  = NW'(b_r);
  assign n_s  = (q_x <<< 1) + {{(NW-1){1'b0}}, rmd_r} + (d_x <<< 2);
  assign d1_s = a_x - b_x;

  // One restoring iteration: shift next dividend bit into the partial remainder, subtract if it fits.
  logic [NW:0]   rem_sh;
  logic [NW+1:0] diff;
  logic          take;
  assign rem_sh = {rem, dvd[NW-1]};
  assign diff   = {1'b0, rem_sh} - {2'b00, dvs};
  assign take   = ~diff[NW+1];

  logic          last;
  logic [NW-1:0] y_v, ym1_v, cf_v;
  logic [NW-W:0] top;
  logic          ovf_v;
  assign last  = (cnt == CW'(NW-1));
  assign y_v   = neg ? -dvd : dvd;
  assign ym1_v = y_v - NW'(1);
  assign cf_v  = neg ? -dvd : dvd;
  assign top   = cf_v[NW-1:W-1];
  assign ovf_v = !((&top) || !(|top));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (io.start) state_nxt = PREP;
      // The a==b path still passes through FIX2 so results are written back in one place.
      PREP:    state_nxt = (d1_s == '0) ? FIX2 : DIV1;
      DIV1:    if (last) state_nxt = FIX1;
      FIX1:    state_nxt = DIV2;
      DIV2:    if (last) state_nxt = FIX2;
      FIX2:    state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q_r <= '0; rmd_r <= 1'b0; a_r <= '0; b_r <= '0; d_r <= '0;
      dvd <= '0; dvs <= '0; rem <= '0; cnt <= '0;
      neg <= 1'b0; div0 <= 1'b0;
      c_r <= '0; err_r <= 1'b0; ovf_r <= 1'b0;
    end else begin
      case (state)
        IDLE: if (io.start) begin
          q_r <= io.q; rmd_r <= io.rmd; a_r <= io.a; b_r <= io.b; d_r <= io.d;
        end
        PREP: begin
          div0 <= (d1_s == '0);
          dvd  <= mag(n_s);
          dvs  <= mag(d1_s);
          rem  <= '0;
          cnt  <= '0;
          neg  <= n_s[NW-1] ^ d1_s[NW-1];
        end
        DIV1, DIV2: begin
          rem <= take ? diff[NW-1:0] : rem_sh[NW-1:0];
          dvd <= {dvd[NW-2:0], take};
          cnt <= cnt + CW'(1);
        end
        FIX1: begin
          dvd <= mag(ym1_v);
          dvs <= NW'(3);
          rem <= '0;
          cnt <= '0;
          neg <= ym1_v[NW-1];
        end
        FIX2: begin
          err_r <= div0;
          c_r   <= div0 ? '0 : cf_v[W-1:0];
          ovf_r <= !div0 && ovf_v;
        end
        default: ;
      endcase
    end
  end

`ifdef MATH_INVERSE_EXACT_CHECK_EN
  logic inx_acc, inx_r;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      inx_acc <= 1'b0;
      inx_r   <= 1'b0;
    end else begin
      case (state)
        PREP:    inx_acc <= 1'b0;
        FIX1:    inx_acc <= |rem;
        FIX2:    inx_r   <= !div0 && (inx_acc || (|rem));
        default: ;
      endcase
    end
  end
  assign io.inexact = inx_r;
`else
  assign io.inexact = 1'b0;
`endif

  assign io.c        = c_r;
  assign io.err_div0 = err_r;
  assign io.ovf      = ovf_r;
  assign io.valid    = (state == DONE);
  assign io.busy     = (state != IDLE);
endmodule

// File: tb/tb_math_expression_inverse.sv
// Directed bench for math_expression_inverse at W=8: hand-computed vectors, latency, flags and reset abort.
module tb_math_expression_inverse;
  localparam int W   = 8;
  localparam int LAT = 48;
`ifdef MATH_INVERSE_EXACT_CHECK_EN
  localparam int EXP_INX4 = 1;
`else
  localparam int EXP_INX4 = 0;
`endif

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  math_expression_inverse_if #(.W(W)) bus ();
  math_expression_inverse #(.W(W)) dut (.clk(clk), .reset(reset), .io(bus));

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, ".c"},        bus.c,        0);
    check({tag, ".valid"},    bus.valid,    0);
    check({tag, ".busy"},     bus.busy,     0);
    check({tag, ".err_div0"}, bus.err_div0, 0);
    check({tag, ".inexact"},  bus.inexact,  0);
    check({tag, ".ovf"},      bus.ovf,      0);
  endtask

  // Called at a negedge; issues one job and follows it to the end of its valid tick.
  task automatic run_job(input string tag, input logic signed [2*W+3:0] q, input logic rmd,
                         input logic signed [W-1:0] a, input logic signed [W-1:0] b,
                         input logic signed [W-1:0] d, input int exp_lat, input int exp_c,
                         input int exp_err, input int exp_inx, input int exp_ovf, input bit hold);
    int lat;
    int busy_ok;
    bus.q = q; bus.rmd = rmd; bus.a = a; bus.b = b; bus.d = d;
    bus.start = 1'b1;
    @(negedge clk);
    if (!hold) bus.start = 1'b0;
    bus.q = (2*W+4)'($urandom); bus.rmd = 1'($urandom);
    bus.a = W'($urandom); bus.b = W'($urandom); bus.d = W'($urandom);
    check({tag, ".busy_rise"}, bus.busy, 1);
    lat = 1;
    busy_ok = 1;
    while (!bus.valid && lat < 200) begin
      if (!bus.busy) busy_ok = 0;
      @(negedge clk);
      lat++;
    end
    bus.start = 1'b0;
    check({tag, ".latency"},  lat, exp_lat);
    check({tag, ".busy_job"}, busy_ok & bus.busy, 1);
    check({tag, ".c"},        bus.c,        exp_c);
    check({tag, ".err_div0"}, bus.err_div0, exp_err);
    check({tag, ".inexact"},  bus.inexact,  exp_inx);
    check({tag, ".ovf"},      bus.ovf,      exp_ovf);
    @(negedge clk);
    check({tag, ".valid_fall"}, bus.valid, 0);
    check({tag, ".busy_fall"},  bus.busy,  0);
    check({tag, ".c_hold"},     bus.c,     exp_c);
  endtask

  initial begin
    int stray;
    reset = 1'b1;
    bus.start = 1'b0; bus.q = '0; bus.rmd = 1'b0; bus.a = '0; bus.b = '0; bus.d = '0;
    repeat (2) @(negedge clk);
    check_outputs_zero("reset_init");
    reset = 1'b0;
    @(negedge clk);

    // N=30, D1=3, Y=10, c=9/3=3
    run_job("basic",  20'sd13,  1'b0, 8'sd5,  8'sd2, 8'sd1, LAT, 3,   0, 0, 0, 1'b0);
    // N=35, D1=-7, Y=-5, c=-6/3=-2
    run_job("neg",    20'sd7,   1'b1, -8'sd4, 8'sd3, 8'sd5, LAT, -2,  0, 0, 0, 1'b0);
    run_job("div0",   20'sd77,  1'b1, 8'sd4,  8'sd4, 8'sd9, 3,   0,   1, 0, 0, 1'b0);
    // N=2, D1=3, Y=0 rem 2; (0-1)/3 = 0 rem -1
    run_job("inexact", 20'sd1,  1'b0, 8'sd5,  8'sd2, 8'sd0, LAT, 0,   0, EXP_INX4, 0, 1'b0);
    // N=601, Y=601, c=200 -> low byte 0xC8 = -56
    run_job("ovf",    20'sd300, 1'b1, 8'sd1,  8'sd0, 8'sd0, LAT, -56, 0, 0, 1, 1'b0);

    bus.q = 20'sd13; bus.rmd = 1'b0; bus.a = 8'sd5; bus.b = 8'sd2; bus.d = 8'sd1;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (9) @(negedge clk);
    check("abort.busy_before", bus.busy, 1);
    reset = 1'b1;
    #1;
    check_outputs_zero("abort_async");
    stray = 0;
    repeat (3) begin
      @(negedge clk);
      if (bus.valid) stray++;
    end
    check("abort.valid_during_reset", stray, 0);
    check_outputs_zero("abort_held");
    reset = 1'b0;

    run_job("post_reset", 20'sd13, 1'b0, 8'sd5, 8'sd2, 8'sd1, LAT, 3, 0, 0, 0, 1'b1);
    stray = 0;
    repeat (60) begin
      @(negedge clk);
      if (bus.valid) stray++;
    end
    check("post_reset.no_stray_valid", stray, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
